// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART byte serializer among
// N_REQ byte sources. A granted byte is launched with a one-cycle ser_start,
// tracked until ser_done, optionally followed by an idle gap, and guarded by
// an optional watchdog that aborts a frame the serializer never finishes.
//
// Build option: define UART_TX_ARB_LOCK_EN to add the req_last port and
// packet locking. While locked, only the locking requester is considered, and
// the round-robin pointer holds. A byte accepted with req_last=1, or a
// watchdog abort, releases the lock.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned GAP_CYC     = 0,
  parameter int unsigned TIMEOUT_CYC = 0,
  parameter int unsigned TW          = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_data,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [N_REQ-1:0]           req_last,
`endif
  output logic [N_REQ-1:0]           req_ready,
  output logic                       ser_start,
  output logic [7:0]                 ser_data,
  input  logic                       ser_done,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       err_timeout
);

  localparam int unsigned IW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_GAP
  } state_e;

  state_e           state_q;
  logic [IW-1:0]    rr_ptr_q;
  logic [TW-1:0]    cnt_q;
  logic [N_REQ-1:0] req_ready_q;
  logic             ser_start_q;
  logic [7:0]       ser_data_q;
  logic [IW-1:0]    grant_id_q;
  logic             busy_q;
  logic             err_timeout_q;

`ifdef UART_TX_ARB_LOCK_EN
  logic             locked_q;
  logic [IW-1:0]    lock_id_q;
`endif

  logic [N_REQ-1:0] cand_valid;
  logic [7:0]       req_byte [N_REQ];
  logic             pick_found;
  logic [IW-1:0]    pick_idx;
  logic [IW-1:0]    cand;

  // Split the flat data bus into one byte per requester.
  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign req_byte[g] = req_data[8*g +: 8];
  end

  // Requesters eligible for the next grant (only the lock owner while locked).
  always_comb begin
    cand_valid = req_valid;
`ifdef UART_TX_ARB_LOCK_EN
    if (locked_q) begin
      cand_valid = req_valid & (N_REQ'(1) << lock_id_q);
    end
`endif
  end

  // Round-robin pick: first eligible requester after rr_ptr, wrapping at N_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IW'((32'(rr_ptr_q) + 32'd1 + i) % N_REQ);
      if (!pick_found && cand_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Arbitration FSM with registered outputs; pulse outputs default low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= IW'(N_REQ - 1);
      cnt_q         <= '0;
      req_ready_q   <= '0;
      ser_start_q   <= 1'b0;
      ser_data_q    <= '0;
      grant_id_q    <= '0;
      busy_q        <= 1'b0;
      err_timeout_q <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
      locked_q      <= 1'b0;
      lock_id_q     <= '0;
`endif
    end else begin
      req_ready_q   <= '0;
      ser_start_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (pick_found) begin
            state_q     <= S_LAUNCH;
            ser_data_q  <= req_byte[pick_idx];
            grant_id_q  <= pick_idx;
            req_ready_q <= N_REQ'(1) << pick_idx;
            ser_start_q <= 1'b1;
            busy_q      <= 1'b1;
`ifdef UART_TX_ARB_LOCK_EN
            if (!locked_q) begin
              rr_ptr_q <= pick_idx;
            end
            locked_q  <= ~req_last[pick_idx];
            lock_id_q <= pick_idx;
`else
            rr_ptr_q    <= pick_idx;
`endif
          end
        end
        S_LAUNCH: begin
          state_q <= S_WAIT;
          cnt_q   <= '0;
        end
        S_WAIT: begin
          // ser_done is tested first so it beats a watchdog expiry in the same cycle.
          if (ser_done) begin
            cnt_q <= '0;
            if (GAP_CYC != 0) begin
              state_q <= S_GAP;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else if ((TIMEOUT_CYC != 0) && (cnt_q == TW'(TIMEOUT_CYC - 1))) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b1;
`ifdef UART_TX_ARB_LOCK_EN
            locked_q      <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == TW'(GAP_CYC - 1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign ser_start   = ser_start_q;
  assign ser_data    = ser_data_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (no gap/no watchdog, and
// GAP_CYC=3/TIMEOUT_CYC=100) driven by directed and randomized steps and
// checked against a round-robin reference model kept in this file.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] vld  [2];
  logic [7:0] dat  [2][4];
  logic [31:0] pd  [2];
  logic       done [2];
  logic [3:0] rdy  [2];
  logic       st   [2];
  logic [7:0] sd   [2];
  logic [1:0] gid  [2];
  logic       bsy  [2];
  logic       err  [2];
`ifdef UART_TX_ARB_LOCK_EN
  logic [3:0] lst  [2];
  int         mlock [2];
  int         mlid  [2];
`endif

  int n_checks = 0;
  int n_errors = 0;
  int mrr [2];

  always #5 clk = ~clk;

  assign pd[0] = {dat[0][3], dat[0][2], dat[0][1], dat[0][0]};
  assign pd[1] = {dat[1][3], dat[1][2], dat[1][1], dat[1][0]};

  uart_tx_arbiter #(.N_REQ(4), .GAP_CYC(0), .TIMEOUT_CYC(0), .TW(16)) u_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (vld[0]),
    .req_data   (pd[0]),
`ifdef UART_TX_ARB_LOCK_EN
    .req_last   (lst[0]),
`endif
    .req_ready  (rdy[0]),
    .ser_start  (st[0]),
    .ser_data   (sd[0]),
    .ser_done   (done[0]),
    .grant_id   (gid[0]),
    .busy       (bsy[0]),
    .err_timeout(err[0])
  );

  uart_tx_arbiter #(.N_REQ(4), .GAP_CYC(3), .TIMEOUT_CYC(100), .TW(16)) u_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (vld[1]),
    .req_data   (pd[1]),
`ifdef UART_TX_ARB_LOCK_EN
    .req_last   (lst[1]),
`endif
    .req_ready  (rdy[1]),
    .ser_start  (st[1]),
    .ser_data   (sd[1]),
    .ser_done   (done[1]),
    .grant_id   (gid[1]),
    .busy       (bsy[1]),
    .err_timeout(err[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Rotate the request vector so the search starts just after rr, take the lowest set bit.
  function automatic int rr_pick(input logic [3:0] v, input int rr);
    logic [7:0] dbl;
    logic [3:0] rot;
    dbl = {v, v};
    rot = 4'(dbl >> (rr + 1));
    for (int j = 0; j < 4; j++) begin
      if (rot[j]) return (rr + 1 + j) % 4;
    end
    return -1;
  endfunction

  function automatic int model_pick(input int d);
`ifdef UART_TX_ARB_LOCK_EN
    if (mlock[d] != 0) return vld[d][mlid[d]] ? mlid[d] : -1;
`endif
    return rr_pick(vld[d], mrr[d]);
  endfunction

  task automatic model_accept(input int d, input int id);
`ifdef UART_TX_ARB_LOCK_EN
    if (mlock[d] == 0) mrr[d] = id;
    mlock[d] = lst[d][id] ? 0 : 1;
    mlid[d]  = id;
`else
    mrr[d] = id;
`endif
  endtask

  task automatic model_reset();
    mrr[0] = 3;
    mrr[1] = 3;
`ifdef UART_TX_ARB_LOCK_EN
    mlock[0] = 0;
    mlock[1] = 0;
`endif
  endtask

  task automatic check_reset_outputs(input int d);
    chk("rst_ready", rdy[d], 0);
    chk("rst_start", st[d], 0);
    chk("rst_data", sd[d], 0);
    chk("rst_grant", gid[d], 0);
    chk("rst_busy", bsy[d], 0);
    chk("rst_err", err[d], 0);
  endtask

  // Assert reset mid-cycle, check outputs cleared immediately, release on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check_reset_outputs(0);
    check_reset_outputs(1);
    done[0] = 1'b0;
    done[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Expect a launch lat cycles from now, then run a frame of len WAIT cycles ending in ser_done.
  task automatic grant_and_frame(input int d, input int lat, input int gap, input int len,
                                 output int id);
    int         exp_id;
    int         cyc;
    logic [7:0] exp_d;
    exp_id = model_pick(d);
    if (exp_id < 0) exp_id = 0;
    exp_d = dat[d][exp_id];
    cyc = 0;
    while (st[d] !== 1'b1 && cyc < lat + 4) begin
      tick();
      cyc++;
    end
    chk("start_latency", cyc, lat);
    chk("req_ready", rdy[d], 32'd1 << exp_id);
    chk("grant_id", gid[d], exp_id);
    chk("ser_data", sd[d], exp_d);
    chk("busy_launch", bsy[d], 1);
    chk("err_launch", err[d], 0);
    model_accept(d, exp_id);
    id = exp_id;
    tick();
    chk("launch_pulse", {st[d], rdy[d]}, 0);
    repeat (len - 1) tick();
    chk("ser_data_hold", sd[d], exp_d);
    done[d] = 1'b1;
    tick();
    done[d] = 1'b0;
    chk("no_timeout", err[d], 0);
    chk("busy_after_done", bsy[d], (gap == 0) ? 32'd0 : 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "time limit");
  end

  initial begin
    int id;
    int cyc;
    int b0;
    int exp_id;
    int held_seq [5];
    int lock_seq [5];
    held_seq = '{0, 1, 2, 3, 0};
`ifdef UART_TX_ARB_LOCK_EN
    lock_seq = '{0, 0, 0, 2, 2};
    lst[0] = 4'hF;
    lst[1] = 4'hF;
`else
    lock_seq = '{0, 2, 0, 2, 0};
`endif
    rst_n   = 1'b0;
    done[0] = 1'b0;
    done[1] = 1'b0;
    vld[0]  = '0;
    vld[1]  = '0;
    for (int d = 0; d < 2; d++) for (int i = 0; i < 4; i++) dat[d][i] = '0;
    model_reset();
    repeat (3) tick();
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst_n = 1'b1;
    tick();

    // Single requester, 10-cycle frame.
    vld[0]    = 4'b0010;
    dat[0][1] = 8'h55;
    grant_and_frame(0, 1, 0, 10, id);
    vld[0] = '0;
    done[0] = 1'b1;
    tick();
    done[0] = 1'b0;
    chk("idle_done_ignored_busy", bsy[0], 0);
    chk("idle_done_ignored_start", st[0], 0);

    // Reset in the middle of a frame, then req0 wins over req3.
    vld[0]    = 4'b0100;
    dat[0][2] = 8'($urandom);
    tick();
    chk("pre_reset_start", st[0], 1);
    tick();
    vld[0]    = 4'b1001;
    dat[0][0] = 8'($urandom);
    dat[0][3] = 8'($urandom);
    tick();
    chk("pre_reset_busy", bsy[0], 1);
    do_reset();
    grant_and_frame(0, 1, 0, $urandom_range(1, 12), id);
    chk("after_reset_first", id, 0);
    vld[0][0] = 1'b0;
    grant_and_frame(0, 1, 0, $urandom_range(1, 12), id);
    chk("after_reset_second", id, 3);
    vld[0] = '0;

    // All four held: strict rotation from reset.
    do_reset();
    vld[0] = 4'b1111;
    for (int i = 0; i < 4; i++) dat[0][i] = 8'($urandom);
    for (int s = 0; s < 5; s++) begin
      grant_and_frame(0, 1, 0, $urandom_range(1, 12), id);
      chk("held_rotation", id, held_seq[s]);
      dat[0][id] = 8'($urandom);
    end

    // Random patterns, frame lengths and withdrawals.
    for (int r = 0; r < 40; r++) begin
      grant_and_frame(0, 1, 0, $urandom_range(1, 12), id);
      dat[0][id] = 8'($urandom);
      vld[0] = 4'($urandom_range(1, 15));
    end
    vld[0] = '0;

    // Gap instance: back-to-back req0 after ser_done, then random traffic.
    vld[1] = 4'b0001;
    for (int i = 0; i < 4; i++) dat[1][i] = 8'($urandom);
    grant_and_frame(1, 1, 3, $urandom_range(1, 20), id);
    dat[1][0] = 8'($urandom);
    grant_and_frame(1, 4, 3, $urandom_range(1, 20), id);
    chk("gap_req0_again", id, 0);
    dat[1][0] = 8'($urandom);
    vld[1] = 4'b1010;
    grant_and_frame(1, 4, 3, 100, id);
    dat[1][id] = 8'($urandom);
    for (int r = 0; r < 15; r++) begin
      grant_and_frame(1, 4, 3, $urandom_range(1, 40), id);
      dat[1][id] = 8'($urandom);
      vld[1] = 4'($urandom_range(1, 15));
    end
    vld[1] = '0;
    repeat (6) tick();

    // Watchdog: no ser_done for a granted byte.
    vld[1] = 4'b0110;
    for (int i = 0; i < 4; i++) dat[1][i] = 8'($urandom);
    exp_id = model_pick(1);
    cyc = 0;
    while (st[1] !== 1'b1 && cyc < 5) begin
      tick();
      cyc++;
    end
    chk("to_start_latency", cyc, 1);
    chk("to_grant", gid[1], exp_id);
    model_accept(1, exp_id);
    vld[1][exp_id] = 1'b0;
    cyc = 0;
    while (err[1] !== 1'b1 && cyc < 150) begin
      tick();
      cyc++;
    end
    chk("timeout_cycles", cyc, 101);
    chk("timeout_busy", bsy[1], 0);
    chk("timeout_start", st[1], 0);
`ifdef UART_TX_ARB_LOCK_EN
    mlock[1] = 0;
`endif
    grant_and_frame(1, 1, 3, $urandom_range(1, 20), id);
    chk("after_timeout_grant", id, (exp_id == 1) ? 32'd2 : 32'd1);
    vld[1] = '0;

    // Packet of three bytes from req0 while req2 stays pending.
    do_reset();
    vld[0] = 4'b0101;
    for (int i = 0; i < 4; i++) dat[0][i] = 8'($urandom);
    b0 = 3;
`ifdef UART_TX_ARB_LOCK_EN
    lst[0][0] = 1'b0;
`endif
    for (int s = 0; s < 5; s++) begin
      grant_and_frame(0, 1, 0, $urandom_range(1, 8), id);
      chk("packet_order", id, lock_seq[s]);
      dat[0][id] = 8'($urandom);
      if (id == 0) begin
        b0--;
        if (b0 == 0) vld[0][0] = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
        lst[0][0] = (b0 == 1);
`endif
      end
    end
    vld[0] = '0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
